// File: rtl/pe_m_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : pe_m_pipe
//  Description : Two-stage pipelined mixed-mode processing element for the
//                systolic array. GEMM multiply-accumulate, or unary (div, exp,
//                log) step using a clamped neighbour operand. It carries a
//                valid tag and a per-operation mode down the pipeline and has
//                a global advance enable.
//                Optional macro PE_ACC_SAT_EN: saturate the stage-2 sum
//                instead of wrapping it.
//  Revision    : 1.0 - initial release
// ============================================================================
module pe_m_pipe #(
    parameter int INT_BW = 5,
    parameter int FRA_BW = 10,
    parameter int MUL_BW = 16,
    parameter int ACC_BW = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              vld_i,
    input  logic [1:0]        mode_i,
    input  logic [ACC_BW-1:0] mac_i,
    input  logic [MUL_BW-1:0] var_i,
    input  logic [MUL_BW-1:0] x_i,
    input  logic [MUL_BW-1:0] wc_i,
    input  logic [ACC_BW-1:0] o_i,
    output logic [ACC_BW-1:0] mac_o,
    output logic [ACC_BW-1:0] o_o,
    output logic [MUL_BW-1:0] var_o,
    output logic [MUL_BW-1:0] x_o,
    output logic [MUL_BW-1:0] wc_o,
    output logic              vld_o,
    output logic [1:0]        mode_o
);

    typedef logic signed [ACC_BW-1:0] acc_t;

    localparam int          c_CLAMP_BW  = INT_BW + 2 * FRA_BW;
    localparam logic [1:0]  c_MODE_GEMM = 2'b00;

    // Range of mac_i that survives truncation to MUL_BW without clamping
    localparam acc_t c_MAC_HI = {{(ACC_BW - c_CLAMP_BW){1'b0}}, {c_CLAMP_BW{1'b1}}};
    localparam acc_t c_MAC_LO = {{(ACC_BW - c_CLAMP_BW){1'b1}}, {c_CLAMP_BW{1'b0}}};

    localparam logic [MUL_BW-1:0] c_MUL_MAX = {1'b0, {(MUL_BW - 1){1'b1}}};
    localparam logic [MUL_BW-1:0] c_MUL_MIN = {1'b1, {(MUL_BW - 1){1'b0}}};

    // Stage 0: operand / tag registers
    logic [MUL_BW-1:0]   wreg_q, ireg_q, vreg_q;
    logic                v0_q;
    logic [1:0]          m0_q;

    // Stage 1: product / addend registers
    logic [2*MUL_BW-1:0] prod_q, prod_d;
    logic [ACC_BW-1:0]   addr_q;
    logic                v1_q;
    logic [1:0]          m1_q;

    // Stage 2: result registers
    logic [ACC_BW-1:0]   oreg_q, oreg_d;
    logic                vld_q;
    logic [1:0]          mode_q;

    // Combinational operand path
    logic [MUL_BW-1:0]   w_mac_t;
    logic [MUL_BW-1:0]   w_a, w_b;
    logic [ACC_BW-1:0]   w_add;

    // Stage-0 registers shift on every enabled edge, valid or not, to keep array skew
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wreg_q <= '0;
            ireg_q <= '0;
            vreg_q <= '0;
            v0_q   <= 1'b0;
            m0_q   <= '0;
        end else if (en) begin
            wreg_q <= wc_i;
            ireg_q <= x_i;
            vreg_q <= var_i;
            v0_q   <= vld_i;
            m0_q   <= mode_i;
        end
    end

    // Truncate the neighbour operand to the operand format, clamping out-of-range values
    always_comb begin
        w_mac_t = mac_i[FRA_BW+MUL_BW-1:FRA_BW];
        if ($signed(mac_i) > c_MAC_HI) begin
            w_mac_t = c_MUL_MAX;
        end else if ($signed(mac_i) < c_MAC_LO) begin
            w_mac_t = c_MUL_MIN;
        end
    end

    // Select multiplier operands and addend from the mode carried with the op
    always_comb begin
        if (m0_q == c_MODE_GEMM) begin
            w_a   = wreg_q;
            w_b   = ireg_q;
            w_add = o_i;
        end else begin
            w_a   = w_mac_t;
            w_b   = vreg_q;
            w_add = acc_t'($signed(wreg_q));
        end
    end

    // Signed product; the low 2*MUL_BW bits of the sign-extended product are exact
    assign prod_d = {{MUL_BW{w_a[MUL_BW-1]}}, w_a} * {{MUL_BW{w_b[MUL_BW-1]}}, w_b};

    // Stage 1 captures only valid ops so bubbles leave the product untouched
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod_q <= '0;
            addr_q <= '0;
            v1_q   <= 1'b0;
            m1_q   <= '0;
        end else if (en) begin
            v1_q <= v0_q;
            if (v0_q) begin
                prod_q <= prod_d;
                addr_q <= w_add;
                m1_q   <= m0_q;
            end
        end
    end

`ifdef PE_ACC_SAT_EN
    typedef logic signed [ACC_BW:0] sum_t;
    sum_t w_sum_wide;

    assign w_sum_wide = sum_t'($signed(prod_q)) + sum_t'($signed(addr_q));

    // Clamp the one-bit-wider sum back into the accumulator range
    always_comb begin
        oreg_d = w_sum_wide[ACC_BW-1:0];
        if (w_sum_wide[ACC_BW] != w_sum_wide[ACC_BW-1]) begin
            oreg_d = w_sum_wide[ACC_BW] ? {1'b1, {(ACC_BW - 1){1'b0}}}
                                        : {1'b0, {(ACC_BW - 1){1'b1}}};
        end
    end
`else
    // Wrapping accumulate at the accumulator width
    assign oreg_d = acc_t'($signed(prod_q)) + $signed(addr_q);
`endif

    // Stage 2 updates the result only for valid ops; vld_o drops for bubbles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            oreg_q <= '0;
            vld_q  <= 1'b0;
            mode_q <= '0;
        end else if (en) begin
            vld_q <= v1_q;
            if (v1_q) begin
                oreg_q <= oreg_d;
                mode_q <= m1_q;
            end
        end
    end

    assign mac_o  = oreg_q;
    assign o_o    = oreg_q;
    assign wc_o   = wreg_q;
    assign x_o    = ireg_q;
    assign var_o  = vreg_q;
    assign vld_o  = vld_q;
    assign mode_o = mode_q;

endmodule
`default_nettype wire

// File: tb/tb_pe_m_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pe_m_pipe
//  Description : Self-checking bench for pe_m_pipe. Directed cases for GEMM,
//                div, clamp, overflow, stall/bubble and mid-op reset, then a
//                random stream compared against an arithmetic reference.
//                Honours PE_ACC_SAT_EN for the expected accumulate behaviour.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pe_m_pipe;

    logic        clk = 1'b0;
    logic        rst_n, en, vld_i;
    logic [1:0]  mode_i;
    logic [31:0] mac_i, o_i;
    logic [15:0] var_i, x_i, wc_i;
    logic [31:0] mac_o, o_o;
    logic [15:0] var_o, x_o, wc_o;
    logic        vld_o;
    logic [1:0]  mode_o;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        vld;
        logic [1:0]  mode;
        logic [15:0] wc;
        logic [15:0] x;
        logic [15:0] vr;
        logic [31:0] mac;
        logic [31:0] o;
    } op_t;

    // Every op accepted on an enabled edge since the last reset, oldest first
    op_t hist[$];

    logic [31:0] exp_res;
    logic        exp_vld;
    logic [1:0]  exp_mode;
    logic [15:0] exp_wc, exp_x, exp_vr;

    pe_m_pipe dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (en),
        .vld_i  (vld_i),
        .mode_i (mode_i),
        .mac_i  (mac_i),
        .var_i  (var_i),
        .x_i    (x_i),
        .wc_i   (wc_i),
        .o_i    (o_i),
        .mac_o  (mac_o),
        .o_o    (o_o),
        .var_o  (var_o),
        .x_o    (x_o),
        .wc_o   (wc_o),
        .vld_o  (vld_o),
        .mode_o (mode_o)
    );

    always #5 clk = ~clk;

    // Reference result of one op from the arithmetic definition
    function automatic logic [31:0] ref_result(input op_t p);
        longint a, b, add, m, s;
        if (p.mode == 2'b00) begin
            a   = longint'($signed(p.wc));
            b   = longint'($signed(p.x));
            add = longint'($signed(p.o));
        end else begin
            m = longint'($signed(p.mac));
            if (m > (longint'(1) << 25) - 1)   a = 32767;
            else if (m < -(longint'(1) << 25)) a = -32768;
            else                               a = m >>> 10;
            b   = longint'($signed(p.vr));
            add = longint'($signed(p.wc));
        end
        s = a * b + add;
`ifdef PE_ACC_SAT_EN
        if (s > 64'sd2147483647)       s = 64'sd2147483647;
        else if (s < -64'sd2147483648) s = -64'sd2147483648;
`endif
        return s[31:0];
    endfunction

    function automatic op_t mk_op(input logic v, input logic [1:0] md, input logic [15:0] wc,
                                  input logic [15:0] x, input logic [15:0] vr,
                                  input logic [31:0] mac, input logic [31:0] o);
        op_t p;
        p.vld = v; p.mode = md; p.wc = wc; p.x = x; p.vr = vr; p.mac = mac; p.o = o;
        return p;
    endfunction

    function automatic op_t rand_op(input logic v);
        op_t p;
        p.vld  = v;
        p.mode = 2'($urandom_range(0, 3));
        p.wc   = 16'($urandom);
        p.x    = 16'($urandom);
        p.vr   = 16'($urandom);
        if ($urandom_range(0, 3) != 0) p.mac = 32'(int'($urandom_range(0, (1 << 26) - 1)) - (1 << 25));
        else                           p.mac = $urandom;
        p.o    = $urandom;
        return p;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ":wc_o"},   32'(wc_o),   32'(exp_wc));
        chk({tag, ":x_o"},    32'(x_o),    32'(exp_x));
        chk({tag, ":var_o"},  32'(var_o),  32'(exp_vr));
        chk({tag, ":o_o"},    o_o,         exp_res);
        chk({tag, ":mac_o"},  mac_o,       exp_res);
        chk({tag, ":vld_o"},  32'(vld_o),  32'(exp_vld));
        chk({tag, ":mode_o"}, 32'(mode_o), 32'(exp_mode));
    endtask

    task automatic clear_expect();
        exp_res = '0; exp_vld = 1'b0; exp_mode = '0;
        exp_wc = '0; exp_x = '0; exp_vr = '0;
    endtask

    // Drive one op (plus mac_i/o_i for the previous op), clock once, update the model, check
    task automatic cycle(input op_t nxt, input logic en_v, input string tag);
        op_t r;
        en     = en_v;
        vld_i  = nxt.vld;
        mode_i = nxt.mode;
        wc_i   = nxt.wc;
        x_i    = nxt.x;
        var_i  = nxt.vr;
        if (hist.size() > 0) begin
            mac_i = hist[hist.size()-1].mac;
            o_i   = hist[hist.size()-1].o;
        end else begin
            mac_i = $urandom;
            o_i   = $urandom;
        end
        @(posedge clk);
        #1;
        if (en_v) begin
            hist.push_back(nxt);
            exp_wc = nxt.wc; exp_x = nxt.x; exp_vr = nxt.vr;
            if (hist.size() >= 3) begin
                r = hist[hist.size()-3];
                exp_vld = r.vld;
                if (r.vld) begin
                    exp_res  = ref_result(r);
                    exp_mode = r.mode;
                end
            end
        end
        check_all(tag);
    endtask

    task automatic directed(input op_t p, input string tag, input logic [31:0] want,
                            input logic [1:0] want_mode);
        cycle(p, 1'b1, tag);
        cycle(rand_op(1'b0), 1'b1, tag);
        cycle(rand_op(1'b0), 1'b1, tag);
        chk({tag, ":const"}, o_o, want);
        chk({tag, ":vld"},   32'(vld_o), 32'd1);
        chk({tag, ":mode"},  32'(mode_o), 32'(want_mode));
    endtask

    initial begin
        logic [31:0] ovf_want;
        int          vld_seen;
        rst_n = 1'b0; en = 1'b0; vld_i = 1'b0; mode_i = '0;
        mac_i = '0; o_i = '0; var_i = '0; x_i = '0; wc_i = '0;
        clear_expect();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        rst_n = 1'b1;

        directed(mk_op(1'b1, 2'b00, 16'd3, 16'd4, 16'd0, 32'd0, 32'd100), "gemm", 32'd112, 2'b00);
        directed(mk_op(1'b1, 2'b01, 16'd7, 16'd0, 16'd5, 32'h0000_0C00, 32'd0), "div", 32'd22, 2'b01);
        directed(mk_op(1'b1, 2'b10, 16'd0, 16'd0, 16'd1, 32'h0400_0000, 32'd0), "clamp_hi",
                 32'h0000_7FFF, 2'b10);
        directed(mk_op(1'b1, 2'b11, 16'd0, 16'd0, 16'd1, 32'hF000_0000, 32'd0), "clamp_lo",
                 32'hFFFF_8000, 2'b11);
`ifdef PE_ACC_SAT_EN
        ovf_want = 32'h7FFF_FFFF;
`else
        ovf_want = 32'hBFFF_0000;
`endif
        directed(mk_op(1'b1, 2'b00, 16'h7FFF, 16'h7FFF, 16'd0, 32'd0, 32'h7FFF_FFFF), "overflow",
                 ovf_want, 2'b00);

        // Back-to-back stream, 3-cycle stall, single bubble, more stream
        for (int i = 0; i < 6; i++) cycle(rand_op(1'b1), 1'b1, "stream_a");
        for (int i = 0; i < 3; i++) cycle(rand_op($urandom_range(0, 1) == 1), 1'b0, "stall");
        cycle(rand_op(1'b0), 1'b1, "bubble");
        for (int i = 0; i < 4; i++) cycle(rand_op(1'b1), 1'b1, "stream_b");

        // Randomised stream with stalls and bubbles
        for (int i = 0; i < 300; i++)
            cycle(rand_op($urandom_range(0, 4) != 0), $urandom_range(0, 7) != 0, "random");

        // Mid-op reset: two valid ops in flight, reset asserted mid-cycle
        cycle(rand_op(1'b1), 1'b1, "pre_rst");
        cycle(rand_op(1'b1), 1'b1, "pre_rst");
        #2 rst_n = 1'b0;
        #1;
        clear_expect();
        check_all("rst_async");
        @(posedge clk);
        #1;
        check_all("rst_hold");
        rst_n = 1'b1;
        hist.delete();
        vld_seen = 0;
        for (int i = 0; i < 3; i++) begin
            cycle(rand_op(1'b0), 1'b1, "post_rst");
            if (vld_o) vld_seen++;
        end
        chk("post_rst_no_vld", 32'(vld_seen), 32'd0);
        directed(mk_op(1'b1, 2'b00, 16'd3, 16'd4, 16'd0, 32'd0, 32'd100), "post_rst_gemm",
                 32'd112, 2'b00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
